// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - round-robin arbiter for the regfile write port with a zero-clear sweep
module regfile_write_arbiter #(
    parameter int NREQ = 4,
    parameter int GW   = 2
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [NREQ-1:0]      ReqValid,
    input  logic [5*NREQ-1:0]    ReqAddr,
    input  logic [32*NREQ-1:0]   ReqData,
    output logic [NREQ-1:0]      ReqReady,
    input  logic                 ClearReq,
    output logic [4:0]           WriteRegister,
    output logic [31:0]          WriteData,
    output logic                 RegWrite,
    output logic [GW-1:0]        GrantId,
    output logic                 InitDone
);

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_e;

    state_e         state_q, state_d;
    logic [4:0]     clr_addr_q, clr_addr_d;
    logic [GW-1:0]  last_grant_q, last_grant_d;
    logic [4:0]     wr_reg_q, wr_reg_d;
    logic [31:0]    wr_data_q, wr_data_d;
    logic           reg_write_q, reg_write_d;
    logic [GW-1:0]  grant_id_q, grant_id_d;
    logic           init_done_q, init_done_d;

    logic           grant_found;
    logic [GW-1:0]  grant_idx;
    logic [GW-1:0]  cand;
    logic [4:0]     sel_addr;
    logic [31:0]    sel_data;

    // Rotating priority: the search starts just past the last granted requester.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        ReqReady    = '0;
        if (state_q == S_RUN) begin
            for (int k = 0; k < NREQ; k++) begin
                cand = GW'((int'(last_grant_q) + 1 + k) % NREQ);
                if (!grant_found && ReqValid[cand]) begin
                    grant_found = 1'b1;
                    grant_idx   = cand;
                end
            end
            if (grant_found) begin
                ReqReady[grant_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx == GW'(i)) begin
                sel_addr = ReqAddr[5*i +: 5];
                sel_data = ReqData[32*i +: 32];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        clr_addr_d   = clr_addr_q;
        last_grant_d = last_grant_q;
        wr_reg_d     = wr_reg_q;
        wr_data_d    = wr_data_q;
        reg_write_d  = 1'b0;
        grant_id_d   = grant_id_q;
        init_done_d  = init_done_q;
        case (state_q)
            S_CLEAR: begin
                reg_write_d = 1'b1;
                wr_reg_d    = clr_addr_q;
                wr_data_d   = '0;
                clr_addr_d  = clr_addr_q + 5'd1;
                if (clr_addr_q == 5'd31) begin
                    state_d     = S_RUN;
                    init_done_d = 1'b1;
                end
            end
            S_RUN: begin
                if (grant_found) begin
                    wr_reg_d     = sel_addr;
                    wr_data_d    = sel_data;
                    last_grant_d = grant_idx;
                    grant_id_d   = grant_idx;
                    // Writes to $0 complete the handshake but never reach the regfile.
                    reg_write_d  = (sel_addr != 5'd0);
                end
                if (ClearReq) begin
                    state_d     = S_CLEAR;
                    clr_addr_d  = 5'd1;
                    init_done_d = 1'b0;
                end
            end
            default: state_d = S_CLEAR;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= S_CLEAR;
            clr_addr_q   <= 5'd1;
            last_grant_q <= GW'(NREQ - 1);
            wr_reg_q     <= '0;
            wr_data_q    <= '0;
            reg_write_q  <= 1'b0;
            grant_id_q   <= '0;
            init_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_addr_q   <= clr_addr_d;
            last_grant_q <= last_grant_d;
            wr_reg_q     <= wr_reg_d;
            wr_data_q    <= wr_data_d;
            reg_write_q  <= reg_write_d;
            grant_id_q   <= grant_id_d;
            init_done_q  <= init_done_d;
        end
    end

    assign WriteRegister = wr_reg_q;
    assign WriteData     = wr_data_q;
    assign RegWrite      = reg_write_q;
    assign GrantId       = grant_id_q;
    assign InitDone      = init_done_q;

endmodule
